noc_local_injector: RTL and testbench

- Store-and-forward packet injector feeding one router's LOCAL input port: drives that port's rx and data_in, and consumes the router's LOCAL credit_o.
- A core streams payload flits plus a destination address. The block buffers the whole packet, then emits header (destination), size (payload flit count) and payload flits under the router credit handshake.
- One instance per router; replaces the behavioural per-router local flit source at the mesh top.

---
 rtl/noc_local_injector.sv | 125 ++++++++++++
 tb/tb_noc_local_injector.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_local_injector.sv
// Store-and-forward injector for a router LOCAL port: buffers a whole core packet, then sends header, size, payload.
// rx rises the cycle after the last accept; credit_i=0 holds the current flit, and core_ready is low until the packet has left.
module noc_local_injector #(
  parameter int TAM_FLIT   = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                core_valid,
  input  logic [TAM_FLIT-1:0] core_data,
  input  logic                core_last,
  input  logic [TAM_FLIT-1:0] core_dest,
  output logic                core_ready,
  output logic                rx,
  output logic [TAM_FLIT-1:0] data_out,
  input  logic                credit_i,
  output logic                busy,
  output logic                pkt_sent
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {LOAD, HEADER, SIZE, PAYLOAD} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [TAM_FLIT-1:0] dest_q, dest_d;
  logic                pkt_sent_q, pkt_sent_d;
  logic [TAM_FLIT-1:0] mem_q [FIFO_DEPTH];

  logic accept;
  logic xfer;
  logic last_rd;

  assign accept  = core_valid & core_ready;
  assign xfer    = rx & credit_i;
  assign last_rd = ({1'b0, rd_ptr_q} == (count_q - CW'(1)));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    dest_d     = dest_q;
    pkt_sent_d = 1'b0;
    core_ready = 1'b0;
    rx         = 1'b0;
    data_out   = '0;
    case (state_q)
      LOAD: begin
        // Gated by reset so nothing is offered while the block is held in reset.
        core_ready = reset;
        if (accept) begin
          count_d = count_q + CW'(1);
          if (count_q == '0) begin
            dest_d = core_dest;
          end
          if (core_last || (count_q == CW'(FIFO_DEPTH - 1))) begin
            state_d = HEADER;
          end
        end
      end
      HEADER: begin
        rx       = 1'b1;
        data_out = dest_q;
        if (xfer) begin
          state_d = SIZE;
        end
      end
      SIZE: begin
        rx       = 1'b1;
        data_out = TAM_FLIT'(count_q);
        if (xfer) begin
          state_d  = PAYLOAD;
          rd_ptr_d = '0;
        end
      end
      PAYLOAD: begin
        rx       = 1'b1;
        data_out = mem_q[rd_ptr_q];
        if (xfer) begin
          if (last_rd) begin
            state_d    = LOAD;
            count_d    = '0;
            rd_ptr_d   = '0;
            pkt_sent_d = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= LOAD;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      dest_q     <= '0;
      pkt_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      dest_q     <= dest_d;
      pkt_sent_q <= pkt_sent_d;
    end
  end

  // Payload storage needs no reset: it is only read back after being written.
  always_ff @(posedge clock) begin
    if (accept) begin
      mem_q[count_q[AW-1:0]] <= core_data;
    end
  end

  assign busy     = (state_q != LOAD) || (count_q != '0);
  assign pkt_sent = pkt_sent_q;

endmodule

// File: tb/tb_noc_local_injector.sv
// Scoreboard bench for noc_local_injector: expected router-side flits are queued at stimulus time, a negedge monitor checks them.
module tb_noc_local_injector;
  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         core_valid = 1'b0;
  logic         core_last = 1'b0;
  logic         credit_i = 1'b1;
  logic [W-1:0] core_data = '0;
  logic [W-1:0] core_dest = '0;
  logic         core_ready;
  logic         rx;
  logic [W-1:0] data_out;
  logic         busy;
  logic         pkt_sent;

  always #5 clock = ~clock;

  noc_local_injector #(.TAM_FLIT(W), .FIFO_DEPTH(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .core_valid (core_valid),
    .core_data  (core_data),
    .core_last  (core_last),
    .core_dest  (core_dest),
    .core_ready (core_ready),
    .rx         (rx),
    .data_out   (data_out),
    .credit_i   (credit_i),
    .busy       (busy),
    .pkt_sent   (pkt_sent)
  );

  typedef struct {
    logic [W-1:0] dat;
    bit           last;
  } exp_t;

  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] stim_dat [32];
  bit           stim_last [32];
  int           rx_cycles = 0;
  int           gap_cnt = 0;
  int           last_gap = 0;
  bit           ps_pend = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for the DUT (t=%0t)", name, $time);
  endtask

  // Router-side monitor: every rx cycle must show the queue head; pop on transfer.
  always @(negedge clock) begin
    if (!reset) begin
      ps_pend = 1'b0;
    end else begin
      if (ps_pend || pkt_sent) check("pkt_sent", 32'(pkt_sent), 32'(ps_pend));
      ps_pend = 1'b0;
      if (rx) begin
        rx_cycles++;
        if (gap_cnt > 0) last_gap = gap_cnt;
        gap_cnt = 0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_flit: got 0x%0h, expected no flit (t=%0t)", data_out, $time);
        end else begin
          check("flit", 32'(data_out), 32'(exp_q[0].dat));
          if (credit_i) begin
            ps_pend = exp_q[0].last;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        gap_cnt++;
      end
    end
  end

  task automatic exp_pkt(input logic [W-1:0] dest, input int first, input int n);
    exp_q.push_back('{dat: dest, last: 1'b0});
    exp_q.push_back('{dat: W'(n), last: 1'b0});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{dat: stim_dat[first+i], last: (i == n - 1)});
    end
  endtask

  task automatic drive_core(input logic [W-1:0] dest, input int n);
    for (int i = 0; i < n; i++) begin
      int budget;
      bit got;
      budget = 200;
      got = 1'b0;
      core_valid = 1'b1;
      core_data  = stim_dat[i];
      core_last  = stim_last[i];
      core_dest  = dest;
      while (!got && budget > 0) begin
        @(negedge clock);
        got = (core_ready === 1'b1);
        @(posedge clock);
        #1;
        budget--;
      end
      if (!got) begin
        fail_now("core_accept");
        break;
      end
    end
    core_valid = 1'b0;
    core_last  = 1'b0;
  endtask

  task automatic wait_out(input logic [W-1:0] v);
    int budget;
    budget = 200;
    while (!(rx === 1'b1 && data_out === v) && budget > 0) begin
      @(posedge clock);
      #1;
      budget--;
    end
    if (budget == 0) fail_now("wait_out");
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 500;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (exp_q.size() != 0) begin
      fail_now(name);
      exp_q.delete();
    end
    repeat (3) @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 32; i++) begin
      stim_dat[i]  = '0;
      stim_last[i] = 1'b0;
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    #11;
    check("rst_rx", 32'(rx), 32'h0);
    check("rst_core_ready", 32'(core_ready), 32'h0);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_pkt_sent", 32'(pkt_sent), 32'h0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("post_rst_core_ready", 32'(core_ready), 32'h1);
    check("post_rst_busy", 32'(busy), 32'h0);
    @(posedge clock);
    #1;

    // Basic three-flit packet
    clear_stim();
    stim_dat[0] = 16'h00A1; stim_dat[1] = 16'h00A2; stim_dat[2] = 16'h00A3; stim_last[2] = 1'b1;
    exp_pkt(16'h0102, 0, 3);
    rx_cycles = 0;
    drive_core(16'h0102, 3);
    wait_drain("basic_drain");
    check("basic_rx_cycles", 32'(rx_cycles), 32'd5);
    check("basic_core_ready", 32'(core_ready), 32'h1);

    // Same packet with credit stalls on SIZE (3) and 0xA2 (2)
    exp_pkt(16'h0102, 0, 3);
    rx_cycles = 0;
    fork
      drive_core(16'h0102, 3);
      begin
        wait_out(16'h0003);
        credit_i = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        credit_i = 1'b1;
        wait_out(16'h00A2);
        credit_i = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
        credit_i = 1'b1;
      end
    join
    wait_drain("stall_drain");
    check("stall_rx_cycles", 32'(rx_cycles), 32'd10);

    // Single-flit packet
    clear_stim();
    stim_dat[0] = 16'h5555; stim_last[0] = 1'b1;
    exp_pkt(16'h0000, 0, 1);
    rx_cycles = 0;
    drive_core(16'h0000, 1);
    wait_drain("single_drain");
    check("single_rx_cycles", 32'(rx_cycles), 32'd3);

    // 20 flits: truncated at 16, remaining 4 form the next packet
    clear_stim();
    for (int i = 0; i < 20; i++) stim_dat[i] = W'(i);
    stim_last[19] = 1'b1;
    exp_pkt(16'h0303, 0, 16);
    exp_pkt(16'h0303, 16, 4);
    rx_cycles = 0;
    fork
      drive_core(16'h0303, 20);
      begin
        wait_out(16'h0010);
        check("trunc_core_ready", 32'(core_ready), 32'h0);
        check("trunc_busy", 32'(busy), 32'h1);
      end
    join
    wait_drain("trunc_drain");
    check("trunc_rx_cycles", 32'(rx_cycles), 32'd24);

    // Reset after two payload transfers, then a clean packet
    clear_stim();
    stim_dat[0] = 16'h00B1; stim_dat[1] = 16'h00B2; stim_dat[2] = 16'h00B3; stim_dat[3] = 16'h00B4; stim_last[3] = 1'b1;
    exp_pkt(16'h0404, 0, 4);
    drive_core(16'h0404, 4);
    begin
      int budget;
      budget = 100;
      while (exp_q.size() > 2 && budget > 0) begin
        @(negedge clock);
        budget--;
      end
      if (budget == 0) fail_now("abort_wait");
    end
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("abort_rx", 32'(rx), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_data_out", 32'(data_out), 32'h0);
    exp_q.delete();
    @(posedge clock);
    #1 reset = 1'b1;
    clear_stim();
    stim_dat[0] = 16'h7777; stim_last[0] = 1'b1;
    exp_pkt(16'h0201, 0, 1);
    rx_cycles = 0;
    drive_core(16'h0201, 1);
    wait_drain("after_reset_drain");
    check("after_reset_rx_cycles", 32'(rx_cycles), 32'd3);

    // Back-to-back two-flit packets with core_valid held high
    clear_stim();
    stim_dat[0] = 16'h00C1; stim_dat[1] = 16'h00C2; stim_last[1] = 1'b1;
    stim_dat[2] = 16'h00C3; stim_dat[3] = 16'h00C4; stim_last[3] = 1'b1;
    exp_pkt(16'h0505, 0, 2);
    exp_pkt(16'h0505, 2, 2);
    rx_cycles = 0;
    drive_core(16'h0505, 4);
    wait_drain("b2b_drain");
    check("b2b_rx_cycles", 32'(rx_cycles), 32'd8);
    check("b2b_gap", 32'(last_gap), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion earlier", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
